alu_operand_issue: RTL

//  ID->EX issue stage directly upstream of the 8-bit ALU (alu). Captures decoded

---
 rtl/alu_operand_issue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_issue.sv
// ID->EX operand issue stage: captures decoded operands, forwards EX/MEM results,
// and presents A/B/ALU_Sel/out_rd to the ALU through a 2-entry skid buffer.
// Ports: clk, rst (async, active-high); decode side in_valid/in_ready, in_a, in_b,
// in_rs_a, in_rs_b, in_sel, in_rd; forwarding fwd_ex_*, fwd_mem_*; flush;
// ALU side out_valid/out_ready, A, B, ALU_Sel, out_rd.
module alu_operand_issue #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_AW-1:0] in_rs_a,
  input  logic [REG_AW-1:0] in_rs_b,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              fwd_ex_valid,
  input  logic [REG_AW-1:0] fwd_ex_rd,
  input  logic [DATA_W-1:0] fwd_ex_data,
  input  logic              fwd_mem_valid,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  output logic [REG_AW-1:0] out_rd
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, b_q, skid_a_q, skid_b_q;
  logic [SEL_W-1:0]  sel_q, skid_sel_q;
  logic [REG_AW-1:0] rd_q, skid_rd_q;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              accept, drain;
  logic              ld_new, ld_skid, ld_from_skid;

  // EX result is younger than MEM, so it wins on a double match.
  function automatic logic [DATA_W-1:0] pick(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] rf,
    input logic              ex_v,
    input logic [REG_AW-1:0] ex_rd,
    input logic [DATA_W-1:0] ex_d,
    input logic              mem_v,
    input logic [REG_AW-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_d
  );
    if (rs == '0)
      return '0;
    else if (ex_v && ex_rd == rs)
      return ex_d;
    else if (mem_v && mem_rd == rs)
      return mem_d;
    else
      return rf;
  endfunction

  assign fwd_a = pick(in_rs_a, in_a, fwd_ex_valid, fwd_ex_rd,
                      fwd_ex_data, fwd_mem_valid, fwd_mem_rd,
                      fwd_mem_data);
  assign fwd_b = pick(in_rs_b, in_b, fwd_ex_valid, fwd_ex_rd,
                      fwd_ex_data, fwd_mem_valid, fwd_mem_rd,
                      fwd_mem_data);

  // in_ready comes straight from the state register: no path from out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_new       = 1'b0;
    ld_skid      = 1'b0;
    ld_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            ld_new  = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            ld_new = 1'b1;
          end else if (accept) begin
            state_d = TWO;
            ld_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d      = ONE;
            ld_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      rd_q       <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_sel_q <= '0;
      skid_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld_new) begin
        a_q   <= fwd_a;
        b_q   <= fwd_b;
        sel_q <= in_sel;
        rd_q  <= in_rd;
      end else if (ld_from_skid) begin
        a_q   <= skid_a_q;
        b_q   <= skid_b_q;
        sel_q <= skid_sel_q;
        rd_q  <= skid_rd_q;
      end
      if (ld_skid) begin
        skid_a_q   <= fwd_a;
        skid_b_q   <= fwd_b;
        skid_sel_q <= in_sel;
        skid_rd_q  <= in_rd;
      end
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign ALU_Sel = sel_q;
  assign out_rd  = rd_q;

endmodule
